// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and default constants for the mult/div sequencer.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOLD  = 2'd3
  } md_state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEF_DATA_W        = 32;
  localparam int DEF_TAG_W         = 5;
  localparam int DEF_TIMEOUT       = 40;
  localparam int DEF_MASK_CYC      = 2;
  localparam int DEF_EXC_RD        = 30;
  localparam int DEF_EXC_MULT_CODE = 4;
  localparam int DEF_EXC_DIV_CODE  = 5;

  // Bits needed to count 0 .. max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Request, unit-side and writeback signals of the mult/div sequencer.
interface multdiv_ctrl_if
  import multdiv_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) ();

  logic              req_valid;
  logic              req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_rd;
  logic              busy;

  logic              ctrl_MULT;
  logic              ctrl_DIV;
  logic [DATA_W-1:0] unit_operandA;
  logic [DATA_W-1:0] unit_operandB;
  logic [DATA_W-1:0] unit_result;
  logic              unit_exception;
  logic              unit_resultRDY;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W-1:0]  wb_rd;
  logic              wb_exception;
  logic              wb_ack;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd,
    output busy,
    output ctrl_MULT, ctrl_DIV, unit_operandA, unit_operandB,
    input  unit_result, unit_exception, unit_resultRDY,
    output wb_valid, wb_data, wb_rd, wb_exception,
    input  wb_ack
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd,
    input  busy,
    input  ctrl_MULT, ctrl_DIV, unit_operandA, unit_operandB,
    output unit_result, unit_exception, unit_resultRDY,
    input  wb_valid, wb_data, wb_rd, wb_exception,
    output wb_ack
  );

endinterface

// File: rtl/multdiv_ctrl_cycle_counter.sv
// Clearable RUN-phase counter saturating at TIMEOUT-1, with mask and timeout flags.
module md_cycle_counter #(
  parameter int TIMEOUT  = 40,
  parameter int MASK_CYC = 2,
  parameter int CNT_W    = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic mask_done_o,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !timeout_o) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign mask_done_o = int'(count_q) >= MASK_CYC;
  assign timeout_o   = (count_q == CNT_LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute stage and the shared iterative mult/div unit.
// Optional macro MULTDIV_DIVZERO_FAST_EN: divide-by-zero completes without running the unit.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int TAG_W         = DEF_TAG_W,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int MASK_CYC      = DEF_MASK_CYC,
  parameter int EXC_RD        = DEF_EXC_RD,
  parameter int EXC_MULT_CODE = DEF_EXC_MULT_CODE,
  parameter int EXC_DIV_CODE  = DEF_EXC_DIV_CODE
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_ctrl_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for req_valid; busy follows req_valid
  // START | one-cycle ctrl_MULT/ctrl_DIV pulse, RUN counter cleared
  // RUN   | waiting for qualified unit_resultRDY or timeout
  // HOLD  | writeback presented until wb_ack

  localparam int                CNT_W      = cnt_width(TIMEOUT);
  localparam logic [TAG_W-1:0]  EXC_RD_T   = TAG_W'(EXC_RD);
  localparam logic [DATA_W-1:0] EXC_MULT_T = DATA_W'(EXC_MULT_CODE);
  localparam logic [DATA_W-1:0] EXC_DIV_T  = DATA_W'(EXC_DIV_CODE);

  md_state_e         state_q, state_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [TAG_W-1:0]  rd_q, rd_d;
  logic              ctrl_mult_q, ctrl_mult_d;
  logic              ctrl_div_q, ctrl_div_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [TAG_W-1:0]  wb_rd_q, wb_rd_d;
  logic              wb_exc_q, wb_exc_d;

  logic cnt_clear, cnt_en, mask_done, timeout;
  logic accept, rdy_qual, run_done, run_exc;

  md_cycle_counter #(
    .TIMEOUT  (TIMEOUT),
    .MASK_CYC (MASK_CYC),
    .CNT_W    (CNT_W)
  ) u_cnt (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (cnt_clear),
    .en_i        (cnt_en),
    .mask_done_o (mask_done),
    .timeout_o   (timeout)
  );

  // Ready beats timeout when both land on the last RUN cycle.
  assign rdy_qual = bus.unit_resultRDY && mask_done;
  assign run_done = rdy_qual || timeout;
  assign run_exc  = rdy_qual ? bus.unit_exception : 1'b1;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_d        = rd_q;
    ctrl_mult_d = 1'b0;
    ctrl_div_d  = 1'b0;
    wb_valid_d  = wb_valid_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_exc_d    = wb_exc_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    accept      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        accept = bus.req_valid;
      end
      ST_START: begin
        cnt_clear = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (run_done) begin
          state_d    = ST_HOLD;
          wb_valid_d = 1'b1;
          wb_exc_d   = run_exc;
          wb_rd_d    = run_exc ? EXC_RD_T : rd_q;
          if (!run_exc) begin
            wb_data_d = bus.unit_result;
          end else begin
            wb_data_d = (op_q == OP_DIV) ? EXC_DIV_T : EXC_MULT_T;
          end
        end
      end
      ST_HOLD: begin
        if (bus.wb_ack) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b0;
          wb_data_d  = '0;
          wb_rd_d    = '0;
          wb_exc_d   = 1'b0;
          accept     = bus.req_valid;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared by IDLE and HOLD so an ack plus a new request needs no bubble.
    if (accept) begin
      op_d        = bus.req_op;
      a_d         = bus.req_a;
      b_d         = bus.req_b;
      rd_d        = bus.req_rd;
      state_d     = ST_START;
      ctrl_mult_d = (bus.req_op == OP_MULT);
      ctrl_div_d  = (bus.req_op == OP_DIV);
`ifdef MULTDIV_DIVZERO_FAST_EN
      if (bus.req_op == OP_DIV && bus.req_b == '0) begin
        state_d    = ST_HOLD;
        ctrl_div_d = 1'b0;
        wb_valid_d = 1'b1;
        wb_exc_d   = 1'b1;
        wb_rd_d    = EXC_RD_T;
        wb_data_d  = EXC_DIV_T;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MULT;
      a_q         <= '0;
      b_q         <= '0;
      rd_q        <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_exc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_q        <= rd_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_exc_q    <= wb_exc_d;
    end
  end

  assign bus.busy          = (state_q == ST_IDLE) ? bus.req_valid : 1'b1;
  assign bus.ctrl_MULT     = ctrl_mult_q;
  assign bus.ctrl_DIV      = ctrl_div_q;
  assign bus.unit_operandA = a_q;
  assign bus.unit_operandB = b_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_exception  = wb_exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl with a cycle-level unit model driven per request.
module tb_multdiv_ctrl;

  localparam int DW       = 32;
  localparam int TW       = 5;
  localparam int TIMEOUT  = 40;
  localparam int MASK_CYC = 2;
  localparam int EXC_RD   = 30;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic          nx_op;
  logic [DW-1:0] nx_a, nx_b;
  logic [TW-1:0] nx_rd;

  multdiv_ctrl_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  multdiv_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // One complete request. pre: request already driven in the previous ack cycle.
  // chain: at the ack cycle present the nx_* request as well.
  task automatic run_op(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TW-1:0] rd, input int n_rdy, input bit stale,
                        input bit uexc, input int ack_dly, input bit pre, input bit chain);
    logic [DW-1:0] res, exp_data;
    logic [TW-1:0] exp_rd;
    logic          exp_exc, exp_m, exp_d;
    bit            fast, rdy;
    int            j_done, lat;

    if (op == 1'b0) res = a * b;
    else if (b != 0) res = $signed(a) / $signed(b);
    else res = 32'($urandom);

    fast = 1'b0;
`ifdef MULTDIV_DIVZERO_FAST_EN
    fast = (op == 1'b1) && (b == 0);
`endif
    // Reference: first RUN cycle (1-based) past the mask window with ready, else timeout.
    j_done  = TIMEOUT;
    exp_exc = 1'b1;
    for (int j = 1; j <= TIMEOUT; j++) begin
      rdy = (j == n_rdy) || (stale && j <= MASK_CYC);
      if (rdy && j > MASK_CYC) begin
        j_done  = j;
        exp_exc = uexc;
        break;
      end
    end
    if (fast) begin
      lat     = 1;
      exp_exc = 1'b1;
    end else begin
      lat = j_done + 2;
    end
    exp_rd   = exp_exc ? TW'(EXC_RD) : rd;
    exp_data = exp_exc ? (op ? 32'd5 : 32'd4) : res;

    if (!pre) begin
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_rd    = rd;
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_on_req got %b exp 1", bus.busy);
      end
    end

    for (int k = 1; k <= lat + ack_dly; k++) begin
      @(negedge clock);
      exp_m = (k == 1) && !fast && (op == 1'b0);
      exp_d = (k == 1) && !fast && (op == 1'b1);
      checks++;
      if (bus.ctrl_MULT !== exp_m || bus.ctrl_DIV !== exp_d) begin
        errors++;
        $display("FAIL ctrl_pulse k=%0d got M%b D%b exp M%b D%b", k, bus.ctrl_MULT, bus.ctrl_DIV, exp_m, exp_d);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_hold k=%0d got %b exp 1", k, bus.busy);
      end
      checks++;
      if (bus.unit_operandA !== a || bus.unit_operandB !== b) begin
        errors++;
        $display("FAIL operands k=%0d got %h/%h exp %h/%h", k, bus.unit_operandA, bus.unit_operandB, a, b);
      end
      checks++;
      if (bus.wb_valid !== (k >= lat)) begin
        errors++;
        $display("FAIL wb_valid k=%0d got %b exp %b (lat %0d)", k, bus.wb_valid, (k >= lat), lat);
      end
      if (k >= lat) begin
        checks++;
        if (bus.wb_data !== exp_data || bus.wb_rd !== exp_rd || bus.wb_exception !== exp_exc) begin
          errors++;
          $display("FAIL wb_fields k=%0d got d=%h rd=%0d e=%b exp d=%h rd=%0d e=%b",
                   k, bus.wb_data, bus.wb_rd, bus.wb_exception, exp_data, exp_rd, exp_exc);
        end
      end

      bus.req_valid      = 1'b0;
      bus.wb_ack         = (k == 2) && !fast;
      bus.unit_resultRDY = ((k - 1) == n_rdy) || (stale && (k - 1) >= 1 && (k - 1) <= MASK_CYC);
      bus.unit_result    = ((k - 1) == n_rdy) ? res : 32'($urandom);
      bus.unit_exception = ((k - 1) == n_rdy) ? uexc : 1'($urandom);
      if (k == lat + ack_dly) begin
        bus.wb_ack = 1'b1;
        if (chain) begin
          bus.req_valid = 1'b1;
          bus.req_op    = nx_op;
          bus.req_a     = nx_a;
          bus.req_b     = nx_b;
          bus.req_rd    = nx_rd;
        end
      end
    end

    if (!chain) begin
      @(negedge clock);
      bus.wb_ack         = 1'b0;
      bus.unit_resultRDY = 1'b0;
      checks++;
      if ({bus.wb_valid, bus.wb_exception, bus.wb_rd, bus.wb_data} !== '0) begin
        errors++;
        $display("FAIL wb_clear got v=%b e=%b rd=%0d d=%h exp all 0",
                 bus.wb_valid, bus.wb_exception, bus.wb_rd, bus.wb_data);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_idle got %b exp 0", bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.ctrl_MULT, bus.ctrl_DIV, bus.unit_operandA, bus.unit_operandB,
         bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_exception} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got M%b D%b A=%h B=%h v=%b d=%h rd=%0d e=%b exp all 0",
               bus.ctrl_MULT, bus.ctrl_DIV, bus.unit_operandA, bus.unit_operandB,
               bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_exception);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", bus.busy);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_mult();
    run_op(1'b0, 32'd6, 32'd7, 5'd5, 17, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_div();
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd9, 32, 1'b0, 1'b0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    run_op(1'b1, 32'd5, 32'd0, 5'd12, 32, 1'b0, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stale_ready();
    run_op(1'b0, 32'($urandom), 32'($urandom), 5'd3, 20, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_op(1'b1, 32'd1000, 32'd9, 5'd4, MASK_CYC + 1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_op(1'b0, 32'd3, 32'd3, 5'd8, 1000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(1'b1, 32'd3, 32'd3, 5'd8, 1000, 1'b1, 1'b0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_ready_at_timeout();
    run_op(1'b0, 32'd11, 32'd13, 5'd21, TIMEOUT, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    nx_op = 1'b1;
    nx_a  = 32'd77;
    nx_b  = 32'd11;
    nx_rd = 5'd0;
    run_op(1'b0, 32'd9, 32'd9, 5'd1, 5, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    run_op(nx_op, nx_a, nx_b, nx_rd, 8, 1'b0, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_op    = 1'b0;
    bus.req_a     = 32'd3;
    bus.req_b     = 32'd4;
    bus.req_rd    = 5'd7;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      bus.req_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({bus.ctrl_MULT, bus.ctrl_DIV, bus.unit_operandA, bus.unit_operandB,
         bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_exception, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run got M%b D%b A=%h B=%h v=%b d=%h rd=%0d e=%b busy=%b exp all 0",
               bus.ctrl_MULT, bus.ctrl_DIV, bus.unit_operandA, bus.unit_operandB,
               bus.wb_valid, bus.wb_data, bus.wb_rd, bus.wb_exception, bus.busy);
    end
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle got busy=%b v=%b exp 0 0", bus.busy, bus.wb_valid);
    end
    run_op(1'b0, 32'd3, 32'd4, 5'd7, 6, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_op(1'($urandom), 32'($urandom), 32'($urandom_range(1, 1000)), 5'($urandom),
             int'($urandom_range(MASK_CYC + 1, TIMEOUT)), 1'($urandom),
             ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_op         = 1'b0;
    bus.req_a          = '0;
    bus.req_b          = '0;
    bus.req_rd         = '0;
    bus.unit_result    = '0;
    bus.unit_exception = 1'b0;
    bus.unit_resultRDY = 1'b0;
    bus.wb_ack         = 1'b0;
    reset              = 1'b1;

    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stale_ready();
    test_timeout();
    test_ready_at_timeout();
    test_back_to_back();
    test_reset_mid_run();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
